// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus pacing FSM feeding uart_tx: one send pulse per byte, spaced
// by a full 10-bit frame plus an idle gap because uart_tx reports no busy.
module uart_tx_feeder #(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 868,
  parameter int SEND_CYCLES  = 10,
  parameter int GAP_CYCLES   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [7:0]               wr_data_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     tx_send_o,
  output logic [7:0]               tx_data_o,
  output logic                     busy_o
);

  localparam int AW           = $clog2(DEPTH);
  localparam int FRAME_CYCLES = 10 * CLKS_PER_BIT + GAP_CYCLES;
  localparam int TMAX         = (FRAME_CYCLES > SEND_CYCLES) ? FRAME_CYCLES : SEND_CYCLES;
  localparam int TW           = $clog2(TMAX + 1);

  localparam logic [TW-1:0] SEND_LOAD  = TW'(SEND_CYCLES - 1);
  localparam logic [TW-1:0] FRAME_LOAD = TW'(FRAME_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [TW-1:0] TIMER_ZERO = TW'(0);
  localparam logic [AW:0]   DEPTH_C    = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ZERO = (AW + 1)'(0);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_nxt;
  logic            w_pop;
  logic            w_push;
  logic            w_nonempty;
  logic [AW:0]     w_count_nxt;

  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW:0]     r_count;
  logic            r_full;
  logic            r_empty;
  logic            r_overflow;
  logic            r_tx_send;
  logic [7:0]      r_tx_data;
  logic            r_busy;

  assign w_nonempty = (r_count != COUNT_ZERO);

  // Next-state, timer reload and pop decision
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_nonempty) begin
          w_pop       = 1'b1;
          w_timer_nxt = SEND_LOAD;
          w_state_nxt = ST_SEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (r_timer == TIMER_ZERO) begin
          w_timer_nxt = FRAME_LOAD;
          w_state_nxt = ST_WAIT;
        end else begin
          w_timer_nxt = r_timer - TIMER_ONE;
        end
      end
      ST_WAIT: begin
        if (r_timer != TIMER_ZERO) begin
          w_timer_nxt = r_timer - TIMER_ONE;
        end else if (w_nonempty) begin
          // Chain straight into the next send so slots stay exactly one frame apart
          w_pop       = 1'b1;
          w_timer_nxt = SEND_LOAD;
          w_state_nxt = ST_SEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_timer_nxt = TIMER_ZERO;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // A pop on this edge frees a slot, so a full FIFO can still accept a write
  always_comb begin
    w_push      = wr_en_i && ((r_count != DEPTH_C) || w_pop);
    w_count_nxt = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
  end

  // FSM state and timer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_timer <= TIMER_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data_i;
    end
  end

  // FIFO pointers, occupancy and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= COUNT_ZERO;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == DEPTH_C);
      r_empty    <= (w_count_nxt == COUNT_ZERO);
      r_overflow <= wr_en_i && !w_push;
    end
  end

  // Registered uart_tx drive and busy indication
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_send <= 1'b0;
      r_tx_data <= 8'h00;
      r_busy    <= 1'b0;
    end else begin
      r_tx_send <= (w_state_nxt == ST_SEND);
      r_busy    <= (w_state_nxt != ST_IDLE);
      if (w_pop) begin
        r_tx_data <= r_mem[r_rd_ptr];
      end
    end
  end

  assign full_o     = r_full;
  assign empty_o    = r_empty;
  assign count_o    = r_count;
  assign overflow_o = r_overflow;
  assign tx_send_o  = r_tx_send;
  assign tx_data_o  = r_tx_data;
  assign busy_o     = r_busy;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: directed scenarios plus random traffic checked
// against a queue-and-timestamp model of the send schedule.
module tb_uart_tx_feeder;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int SEND  = 10;
  localparam int GAP   = 2;
  localparam int SLOT  = SEND + 10 * CPB + GAP;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full_o, empty_o, overflow_o, tx_send_o, busy_o;
  logic [2:0] count_o;
  logic [7:0] tx_data_o;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .SEND_CYCLES(SEND), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
    .overflow_o(overflow_o), .tx_send_o(tx_send_o), .tx_data_o(tx_data_o),
    .busy_o(busy_o)
  );

  int vectors = 0;
  int miscompares = 0;
  int t = 0;

  // Reference model: FIFO as a queue, a pop allowed once a whole slot has
  // elapsed since the previous pop (or immediately when nothing is pending).
  logic [7:0] q[$];
  int         last_pop = 0;
  bit         have_pop = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         m_ovf = 1'b0;

  task automatic model_edge(input logic w, input logic [7:0] d, input logic r);
    bit pop, acc;
    if (r) begin
      q.delete();
      have_pop = 1'b0;
      m_data   = 8'h00;
      m_ovf    = 1'b0;
    end else begin
      pop   = (q.size() != 0) && (!have_pop || (t - last_pop) >= SLOT);
      acc   = w && ((q.size() < DEPTH) || pop);
      m_ovf = w && !acc;
      if (pop) begin
        m_data   = q.pop_front();
        last_pop = t;
        have_pop = 1'b1;
      end
      if (acc) q.push_back(d);
    end
  endtask

  function automatic bit exp_send();
    return have_pop && ((t - last_pop) < SEND);
  endfunction

  function automatic bit exp_busy();
    return have_pop && ((t - last_pop) < SLOT);
  endfunction

  task automatic tick(input logic w, input logic [7:0] d, input logic r);
    wr_en   = w;
    wr_data = d;
    rst     = r;
    @(posedge clk);
    t++;
    model_edge(w, d, r);
    #1;
  endtask

  task automatic wait_rise(input int budget, output bit found);
    bit prev;
    found = 1'b0;
    prev  = tx_send_o;
    for (int i = 0; i < budget && !found; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      if (tx_send_o && !prev) found = 1'b1;
      prev = tx_send_o;
    end
  endtask

  task automatic test_reset();
    repeat (5) tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %0b exp 1", empty_o); end
    vectors++; if (full_o !== 1'b0) begin miscompares++; $display("FAIL reset_full got %0b exp 0", full_o); end
    vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count_o); end
    vectors++; if (overflow_o !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %0b exp 0", overflow_o); end
    vectors++; if (tx_send_o !== 1'b0) begin miscompares++; $display("FAIL reset_send got %0b exp 0", tx_send_o); end
    vectors++; if (tx_data_o !== 8'h00) begin miscompares++; $display("FAIL reset_data got %0h exp 00", tx_data_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b exp 0", busy_o); end
  endtask

  task automatic test_single();
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h55, 1'b0);  // edge N
    vectors++; if (empty_o !== 1'b0) begin miscompares++; $display("FAIL single_empty_n got %0b exp 0", empty_o); end
    vectors++; if (count_o !== 3'd1) begin miscompares++; $display("FAIL single_count_n got %0d exp 1", count_o); end
    vectors++; if (tx_send_o !== 1'b0) begin miscompares++; $display("FAIL single_send_n got %0b exp 0", tx_send_o); end
    tick(1'b0, 8'h00, 1'b0);  // edge N+1
    vectors++; if (tx_send_o !== 1'b1) begin miscompares++; $display("FAIL single_send_n1 got %0b exp 1", tx_send_o); end
    vectors++; if (tx_data_o !== 8'h55) begin miscompares++; $display("FAIL single_data got %0h exp 55", tx_data_o); end
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("FAIL single_empty_n1 got %0b exp 1", empty_o); end
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL single_busy_n1 got %0b exp 1", busy_o); end
    for (int k = 2; k <= 10; k++) begin
      tick(1'b0, 8'h00, 1'b0);
      vectors++; if (tx_send_o !== 1'b1) begin miscompares++; $display("FAIL single_send_hold k=%0d got %0b exp 1", k, tx_send_o); end
    end
    tick(1'b0, 8'h00, 1'b0);  // edge N+11
    vectors++; if (tx_send_o !== 1'b0) begin miscompares++; $display("FAIL single_send_end got %0b exp 0", tx_send_o); end
    for (int k = 12; k <= 50; k++) tick(1'b0, 8'h00, 1'b0);
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL single_busy_wait got %0b exp 1", busy_o); end
    vectors++; if (tx_data_o !== 8'h55) begin miscompares++; $display("FAIL single_data_hold got %0h exp 55", tx_data_o); end
    for (int k = 51; k <= 54; k++) tick(1'b0, 8'h00, 1'b0);
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL single_busy_end got %0b exp 0", busy_o); end
  endtask

  task automatic test_burst();
    logic [7:0] b [4];
    int         rise_t[$];
    logic [7:0] rise_d[$];
    int         peak;
    bit         prev;
    b[0] = 8'h55; b[1] = 8'h66; b[2] = 8'hA5; b[3] = 8'h0F;
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    peak = 0;
    prev = 1'b0;
    for (int i = 0; i < 4 * SLOT + 10; i++) begin
      if (i < 4) tick(1'b1, b[i], 1'b0);
      else       tick(1'b0, 8'h00, 1'b0);
      if (int'(count_o) > peak) peak = int'(count_o);
      if (tx_send_o && !prev) begin
        rise_t.push_back(t);
        rise_d.push_back(tx_data_o);
      end
      prev = tx_send_o;
    end
    vectors++; if (peak !== 3) begin miscompares++; $display("FAIL burst_peak got %0d exp 3", peak); end
    vectors++; if (rise_t.size() !== 4) begin miscompares++; $display("FAIL burst_rises got %0d exp 4", rise_t.size()); end
    for (int i = 0; i < 4 && i < rise_t.size(); i++) begin
      vectors++; if (rise_d[i] !== b[i]) begin miscompares++; $display("FAIL burst_data[%0d] got %0h exp %0h", i, rise_d[i], b[i]); end
      if (i > 0) begin
        vectors++; if (rise_t[i] - rise_t[i-1] !== SLOT) begin miscompares++; $display("FAIL burst_gap[%0d] got %0d exp %0d", i, rise_t[i] - rise_t[i-1], SLOT); end
      end
    end
  endtask

  task automatic test_overflow_full_pop();
    logic [7:0] exp_order [4];
    bit         found;
    exp_order[0] = 8'hA2; exp_order[1] = 8'hA3; exp_order[2] = 8'hA4; exp_order[3] = 8'hB6;
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h11, 1'b0);
    repeat (16) tick(1'b0, 8'h00, 1'b0);
    vectors++; if (busy_o !== 1'b1 || tx_send_o !== 1'b0 || count_o !== 3'd0) begin
      miscompares++; $display("FAIL ovf_midwait busy/send/count got %0b/%0b/%0d exp 1/0/0", busy_o, tx_send_o, count_o);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 8'hA1 + 8'(i), 1'b0);
      if (i == 3) begin
        vectors++; if (full_o !== 1'b1) begin miscompares++; $display("FAIL ovf_full got %0b exp 1", full_o); end
        vectors++; if (overflow_o !== 1'b0) begin miscompares++; $display("FAIL ovf_early got %0b exp 0", overflow_o); end
      end
    end
    vectors++; if (overflow_o !== 1'b1) begin miscompares++; $display("FAIL ovf_pulse got %0b exp 1", overflow_o); end
    vectors++; if (count_o !== 3'd4) begin miscompares++; $display("FAIL ovf_count got %0d exp 4", count_o); end
    tick(1'b0, 8'h00, 1'b0);
    vectors++; if (overflow_o !== 1'b0) begin miscompares++; $display("FAIL ovf_single_cycle got %0b exp 0", overflow_o); end
    while (t < last_pop + SLOT - 1) tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'hB6, 1'b0);  // WAIT expiry edge with a write on a full FIFO
    vectors++; if (count_o !== 3'd4) begin miscompares++; $display("FAIL fullpop_count got %0d exp 4", count_o); end
    vectors++; if (overflow_o !== 1'b0) begin miscompares++; $display("FAIL fullpop_ovf got %0b exp 0", overflow_o); end
    vectors++; if (tx_send_o !== 1'b1 || tx_data_o !== 8'hA1) begin
      miscompares++; $display("FAIL fullpop_send got %0b/%0h exp 1/a1", tx_send_o, tx_data_o);
    end
    for (int i = 0; i < 4; i++) begin
      wait_rise(SLOT + 5, found);
      vectors++; if (!found || tx_data_o !== exp_order[i]) begin
        miscompares++; $display("FAIL fullpop_order[%0d] got found=%0b data=%0h exp %0h", i, found, tx_data_o, exp_order[i]);
      end
    end
    wait_rise(SLOT + 5, found);
    vectors++; if (found !== 1'b0) begin miscompares++; $display("FAIL fullpop_extra_send got %0b exp 0", found); end
  endtask

  task automatic test_reset_mid();
    bit found;
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h77, 1'b0);
    tick(1'b1, 8'h88, 1'b0);
    tick(1'b1, 8'h99, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    vectors++; if (tx_send_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_send got %0b exp 0", tx_send_o); end
    vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL rstmid_count got %0d exp 0", count_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %0b exp 0", busy_o); end
    vectors++; if (empty_o !== 1'b1 || tx_data_o !== 8'h00) begin miscompares++; $display("FAIL rstmid_empty_data got %0b/%0h exp 1/00", empty_o, tx_data_o); end
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h66, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    vectors++; if (tx_send_o !== 1'b1 || tx_data_o !== 8'h66) begin
      miscompares++; $display("FAIL rstmid_resend got %0b/%0h exp 1/66", tx_send_o, tx_data_o);
    end
    wait_rise(SLOT + 10, found);
    vectors++; if (found !== 1'b0) begin miscompares++; $display("FAIL rstmid_stale_send got %0b exp 0", found); end
  endtask

  task automatic test_random();
    int         pct;
    logic       w, r;
    logic [7:0] d;
    logic [2:0] ec;
    tick(1'b0, 8'h00, 1'b1);
    pct = 10;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        case ($urandom_range(0, 2))
          0:       pct = 2;
          1:       pct = 10;
          default: pct = 60;
        endcase
      end
      w = ($urandom_range(0, 99) < pct);
      r = ($urandom_range(0, 399) == 0);
      d = 8'($urandom_range(0, 255));
      tick(w, d, r);
      ec = 3'(q.size());
      vectors++; if (count_o !== ec) begin miscompares++; $display("FAIL rnd_count t=%0d got %0d exp %0d", t, count_o, ec); end
      vectors++; if (full_o !== (q.size() == DEPTH)) begin miscompares++; $display("FAIL rnd_full t=%0d got %0b", t, full_o); end
      vectors++; if (empty_o !== (q.size() == 0)) begin miscompares++; $display("FAIL rnd_empty t=%0d got %0b", t, empty_o); end
      vectors++; if (overflow_o !== m_ovf) begin miscompares++; $display("FAIL rnd_ovf t=%0d got %0b exp %0b", t, overflow_o, m_ovf); end
      vectors++; if (tx_send_o !== exp_send()) begin miscompares++; $display("FAIL rnd_send t=%0d got %0b exp %0b", t, tx_send_o, exp_send()); end
      vectors++; if (tx_data_o !== m_data) begin miscompares++; $display("FAIL rnd_data t=%0d got %0h exp %0h", t, tx_data_o, m_data); end
      vectors++; if (busy_o !== exp_busy()) begin miscompares++; $display("FAIL rnd_busy t=%0d got %0b exp %0b", t, busy_o, exp_busy()); end
    end
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    test_reset();
    test_single();
    test_burst();
    test_overflow_full_pop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
